booth_pp_acc_18x18: RTL and testbench



---
 rtl/booth_pp_acc_18x18_if.sv | 31 +++
 rtl/booth_pp_acc_18x18.sv | 113 +++++++++++
 tb/tb_booth_pp_acc_18x18.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_pp_acc_18x18_if.sv
// Partial-product set in, 36-bit product out, valid/ready on both sides.
interface booth_pp_acc_18x18_if;
  logic [19:0] i_pp1;
  logic [19:0] i_pp2;
  logic [19:0] i_pp3;
  logic [19:0] i_pp4;
  logic [19:0] i_pp5;
  logic [19:0] i_pp6;
  logic [19:0] i_pp7;
  logic [19:0] i_pp8;
  logic [19:0] i_pp9;
  logic [19:0] i_pp10;
  logic        i_valid;
  logic        o_ready;
  logic [35:0] o_prod;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;

  modport master (
    output i_pp1, i_pp2, i_pp3, i_pp4, i_pp5, i_pp6, i_pp7, i_pp8, i_pp9, i_pp10,
    output i_valid, i_ready,
    input  o_ready, o_prod, o_valid, o_busy
  );

  modport slave (
    input  i_pp1, i_pp2, i_pp3, i_pp4, i_pp5, i_pp6, i_pp7, i_pp8, i_pp9, i_pp10,
    input  i_valid, i_ready,
    output o_ready, o_prod, o_valid, o_busy
  );
endinterface

// File: rtl/booth_pp_acc_18x18.sv
// Sums ten Booth radix-4 partial products, PPC per cycle; result valid N+1 edges after accept (N=10/PPC).
// Accepts only in IDLE; holds the product in DONE until i_ready, one result per N+2 cycles.
module booth_pp_acc_18x18 #(
  parameter int PPC = 2
) (
  input logic                  i_clk,
  input logic                  i_rst,
  booth_pp_acc_18x18_if.slave  bus
);

  if (!(PPC == 1 || PPC == 2 || PPC == 5 || PPC == 10)) begin : g_ppc_illegal
    $error("booth_pp_acc_18x18: PPC must be 1, 2, 5 or 10");
  end

  localparam logic [3:0] PPC_STEP = 4'(PPC);
  localparam logic [3:0] LAST_IDX = 4'(10 - PPC);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t      state_q;
  logic [19:0] pp_q  [10];
  logic [19:0] pp_in [10];
  logic [39:0] acc_q;
  logic [39:0] acc_nxt;
  logic [39:0] term;
  logic [3:0]  sel;
  logic [3:0]  idx_q;
  logic        ready_q;
  logic        valid_q;
  logic        busy_q;
  logic [35:0] prod_q;

  assign pp_in[0] = bus.i_pp1;
  assign pp_in[1] = bus.i_pp2;
  assign pp_in[2] = bus.i_pp3;
  assign pp_in[3] = bus.i_pp4;
  assign pp_in[4] = bus.i_pp5;
  assign pp_in[5] = bus.i_pp6;
  assign pp_in[6] = bus.i_pp7;
  assign pp_in[7] = bus.i_pp8;
  assign pp_in[8] = bus.i_pp9;
  assign pp_in[9] = bus.i_pp10;

  // Each step folds PPC sign-extended terms, weight 4^index, lowest index first.
  always_comb begin
    acc_nxt = acc_q;
    sel     = '0;
    term    = '0;
    for (int j = 0; j < PPC; j++) begin
      sel     = idx_q + 4'(j);
      term    = {{20{pp_q[sel][19]}}, pp_q[sel]} << {sel, 1'b0};
      acc_nxt = acc_nxt + term;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      for (int i = 0; i < 10; i++) pp_q[i] <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            for (int i = 0; i < 10; i++) pp_q[i] <= pp_in[i];
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= ACC;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ACC: begin
          acc_q <= acc_nxt;
          idx_q <= idx_q + PPC_STEP;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            prod_q  <= acc_nxt[35:0];
          end
        end
        DONE: begin
          // Product stays zero outside DONE, so it is cleared on the way out.
          if (bus.i_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            prod_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          prod_q  <= '0;
        end
      endcase
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_prod  = prod_q;

endmodule

// File: tb/tb_booth_pp_acc_18x18.sv
// Runs PPC=1,2,5,10 instances side by side against a Booth encoder model and plain multiplication.
module tb_booth_pp_acc_18x18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        ready = 1'b1;
  logic [19:0] pp [10];

  logic [3:0]  rdy_a;
  logic [3:0]  vld_a;
  logic [3:0]  busy_a;
  logic [35:0] prod_a [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int P = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 5 : 10;
    booth_pp_acc_18x18_if bus();
    assign bus.i_pp1   = pp[0];
    assign bus.i_pp2   = pp[1];
    assign bus.i_pp3   = pp[2];
    assign bus.i_pp4   = pp[3];
    assign bus.i_pp5   = pp[4];
    assign bus.i_pp6   = pp[5];
    assign bus.i_pp7   = pp[6];
    assign bus.i_pp8   = pp[7];
    assign bus.i_pp9   = pp[8];
    assign bus.i_pp10  = pp[9];
    assign bus.i_valid = valid;
    assign bus.i_ready = ready;
    booth_pp_acc_18x18 #(.PPC(P)) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
    );
    assign rdy_a[gi]  = bus.o_ready;
    assign vld_a[gi]  = bus.o_valid;
    assign busy_a[gi] = bus.o_busy;
    assign prod_a[gi] = bus.o_prod;
  end

  function automatic int ppc_of(input int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 5;
      default: return 10;
    endcase
  endfunction

  function automatic int lat_of(input int g);
    return 10 / ppc_of(g) + 1;
  endfunction

  function automatic longint opnd(input logic [17:0] v, input bit sgn);
    if (sgn) return longint'($signed(v));
    return longint'({46'd0, v});
  endfunction

  function automatic logic [35:0] model_prod(input logic [17:0] a, input bit as,
                                              input logic [17:0] b, input bit bs);
    logic [63:0] p;
    p = 64'(opnd(a, as) * opnd(b, bs));
    return p[35:0];
  endfunction

  function automatic longint bit_of(input longint x, input int i);
    if (i < 0) return 0;
    return (x >>> i) & 64'sd1;
  endfunction

  // Radix-4 Booth encoding of b, ten digits, each multiplied by a.
  task automatic set_pp(input logic [17:0] a, input bit as, input logic [17:0] b, input bit bs);
    longint ax, bx, d;
    logic [63:0] v;
    ax = opnd(a, as);
    bx = opnd(b, bs);
    for (int k = 0; k < 10; k++) begin
      d = -2 * bit_of(bx, 2*k+1) + bit_of(bx, 2*k) + bit_of(bx, 2*k-1);
      v = 64'(d * ax);
      pp[k] = v[19:0];
    end
  endtask

  task automatic randomize_pp();
    for (int k = 0; k < 10; k++) pp[k] = 20'($urandom);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = 1'b1;
    ready = 1'b1;
    randomize_pp();
    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if ({rdy_a[g], vld_a[g], busy_a[g]} !== 3'b100 || prod_a[g] !== 36'd0) begin
        errors++;
        $display("FAIL reset_state ppc=%0d got rdy/vld/busy=%b prod=%h want 100 prod=0",
                 ppc_of(g), {rdy_a[g], vld_a[g], busy_a[g]}, prod_a[g]);
      end
    end
    valid = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op(input logic [17:0] a, input bit as, input logic [17:0] b, input bit bs,
                        input string name);
    logic [35:0] expv;
    logic [35:0] got [4];
    int          first [4];
    bit          nz [4];
    expv  = model_prod(a, as, b, bs);
    set_pp(a, as, b, bs);
    ready = 1'b1;
    valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      first[g] = 0;
      got[g]   = '0;
      nz[g]    = 1'b0;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) valid = 1'b0;
      randomize_pp();
      for (int g = 0; g < 4; g++) begin
        if (vld_a[g] === 1'b1) begin
          if (first[g] == 0) begin
            first[g] = k;
            got[g]   = prod_a[g];
          end
        end else if (prod_a[g] !== 36'd0) begin
          nz[g] = 1'b1;
        end
      end
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (first[g] != lat_of(g)) begin
        errors++;
        $display("FAIL %s_latency ppc=%0d got=%0d want=%0d", name, ppc_of(g), first[g], lat_of(g));
      end
      checks++;
      if (got[g] !== expv) begin
        errors++;
        $display("FAIL %s_prod ppc=%0d got=%h want=%h", name, ppc_of(g), got[g], expv);
      end
      checks++;
      if (nz[g]) begin
        errors++;
        $display("FAIL %s_prod_zero_idle ppc=%0d got=nonzero want=0", name, ppc_of(g));
      end
    end
  endtask

  task automatic test_vectors();
    run_op(18'h3FFFF, 1'b0, 18'h3FFFF, 1'b0, "uu_max");
    run_op(18'h20000, 1'b1, 18'h20000, 1'b1, "ss_min");
    run_op(18'h3FFFF, 1'b1, 18'h3FFFF, 1'b1, "ss_m1");
    run_op(18'h3FFFF, 1'b1, 18'h3FFFF, 1'b0, "su_mixed");
    run_op(18'h3FFFF, 1'b0, 18'h20000, 1'b1, "us_mixed");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      run_op(18'($urandom), 1'($urandom), 18'($urandom), 1'($urandom), "rand");
    end
  endtask

  task automatic test_backpressure();
    logic [35:0] expv;
    logic [35:0] got [4];
    int          first [4];
    bit          unstable [4];
    expv = model_prod(18'h2A5C3, 1'b1, 18'h1F0F1, 1'b0);
    set_pp(18'h2A5C3, 1'b1, 18'h1F0F1, 1'b0);
    ready = 1'b0;
    valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      first[g]    = 0;
      got[g]      = '0;
      unstable[g] = 1'b0;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      valid = 1'($urandom);
      randomize_pp();
      for (int g = 0; g < 4; g++) begin
        if (first[g] == 0) begin
          if (vld_a[g] === 1'b1) begin
            first[g] = k;
            got[g]   = prod_a[g];
          end
        end else if (vld_a[g] !== 1'b1 || prod_a[g] !== got[g]) begin
          unstable[g] = 1'b1;
        end
      end
    end
    valid = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (first[g] != lat_of(g) || got[g] !== expv) begin
        errors++;
        $display("FAIL bp_result ppc=%0d got lat=%0d prod=%h want lat=%0d prod=%h",
                 ppc_of(g), first[g], got[g], lat_of(g), expv);
      end
      checks++;
      if (unstable[g]) begin
        errors++;
        $display("FAIL bp_hold ppc=%0d got=changed want=stable", ppc_of(g));
      end
      checks++;
      if ({rdy_a[g], vld_a[g], busy_a[g]} !== 3'b100 || prod_a[g] !== 36'd0) begin
        errors++;
        $display("FAIL bp_release ppc=%0d got rdy/vld/busy=%b prod=%h want 100 prod=0",
                 ppc_of(g), {rdy_a[g], vld_a[g], busy_a[g]}, prod_a[g]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int stale [4];
    set_pp(18'h3FFFF, 1'b0, 18'h3FFFF, 1'b0);
    ready = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      checks++;
      if ({rdy_a[g], vld_a[g], busy_a[g]} !== 3'b100 || prod_a[g] !== 36'd0) begin
        errors++;
        $display("FAIL midreset_state ppc=%0d got rdy/vld/busy=%b prod=%h want 100 prod=0",
                 ppc_of(g), {rdy_a[g], vld_a[g], busy_a[g]}, prod_a[g]);
      end
      stale[g] = 0;
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) if (vld_a[g] !== 1'b0) stale[g]++;
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (stale[g] != 0) begin
        errors++;
        $display("FAIL midreset_stale_valid ppc=%0d got=%0d cycles want=0", ppc_of(g), stale[g]);
      end
    end
    run_op(18'd5, 1'b0, 18'd7, 1'b0, "after_reset");
  endtask

  initial begin
    for (int k = 0; k < 10; k++) pp[k] = '0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
